// File: rtl/idli_sqi_ram_m_if.sv
// SQI link between the core's SQI controller (master) and the RAM responder (slave).
// Serial clock, chip select and data travel controller -> RAM on the i_ram_* lines;
// read data and its output enable travel back on the o_ram_* lines.
interface idli_sqi_ram_m_if;
  logic       i_ram_sck;
  logic       i_ram_cs;
  logic [3:0] i_ram_sio;
  logic [3:0] o_ram_sio;
  logic       o_ram_sio_oe;

  modport master (
    output i_ram_sck,
    output i_ram_cs,
    output i_ram_sio,
    input  o_ram_sio,
    input  o_ram_sio_oe
  );

  modport slave (
    input  i_ram_sck,
    input  i_ram_cs,
    input  i_ram_sio,
    output o_ram_sio,
    output o_ram_sio_oe
  );
endinterface

// File: rtl/idli_sqi_ram_m.sv
// SQI RAM responder: decodes READ (0x03) / WRITE (0x02) commands nibble by
// nibble from the SQI link, services sequential byte bursts against an
// internal 2^ADDR_W byte array and drives read nibbles back on the SIO lines.
// The serial clock is oversampled by the core clock; inputs are taken on sck
// rise, outputs change on sck fall. ADDR_W must be a multiple of 4 and
// DUMMY must be at least 1.
module idli_sqi_ram_m #(
  parameter int ADDR_W = 16,
  parameter int DUMMY  = 2
) (
  input  logic                 i_ram_gck,
  input  logic                 i_ram_rst,
  idli_sqi_ram_m_if.slave      bus
);

  localparam int ADDR_NIBS = ADDR_W / 4;
  localparam int CNT_MAX_A = (ADDR_NIBS > DUMMY) ? ADDR_NIBS : DUMMY;
  localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int MEM_DEPTH = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] CNT_ZERO      = '0;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_NIBS - 1);
  localparam logic [CNT_W-1:0] CNT_DUMMY_END = CNT_W'(DUMMY);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_SKIP
  } state_t;

  state_t state_q, state_nxt;

  logic              sck_q;
  logic              rise, fall;
  logic              cs_n_high;
  logic [3:0]        sio_in;
  logic [7:0]        cmd_byte;

  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt, addr_inc;
  logic [3:0]        cmd_hi_q, cmd_hi_nxt;
  logic              is_read_q, is_read_nxt;
  logic              half_q, half_nxt;
  logic [3:0]        hi_nib_q, hi_nib_nxt;
  logic [3:0]        sio_q, sio_nxt;
  logic              oe_q, oe_nxt;

  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        rd_cur, rd_next;

  logic [7:0]        mem [0:MEM_DEPTH-1];

  // Edge events are masked while deselected so deselect always wins over a coincident rise.
  assign cs_n_high = bus.i_ram_cs;
  assign rise      = bus.i_ram_sck & ~sck_q & ~cs_n_high;
  assign fall      = ~bus.i_ram_sck & sck_q & ~cs_n_high;
  assign sio_in    = bus.i_ram_sio;
  assign cmd_byte  = {cmd_hi_q, sio_in};
  assign addr_inc  = addr_q + ADDR_W'(1);
  assign rd_cur    = mem[addr_q];
  assign rd_next   = mem[addr_inc];

  assign bus.o_ram_sio    = sio_q;
  assign bus.o_ram_sio_oe = oe_q;

  // Delayed copy of the serial clock for rise/fall detection.
  always_ff @(posedge i_ram_gck) begin
    if (i_ram_rst) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= bus.i_ram_sck;
    end
  end

  // FSM state register.
  always_ff @(posedge i_ram_gck) begin
    if (i_ram_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode: walks command, address, dummy and data phases on sck edges.
  always_comb begin
    state_nxt = state_q;
    if (cs_n_high) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_nxt = S_CMD;
        end
        S_CMD: begin
          if (rise && cnt_q == CNT_ONE) begin
            if (cmd_byte == CMD_READ || cmd_byte == CMD_WRITE) begin
              state_nxt = S_ADDR;
            end else begin
              state_nxt = S_SKIP;
            end
          end
        end
        S_ADDR: begin
          if (rise && cnt_q == CNT_ADDR_LAST) begin
            state_nxt = is_read_q ? S_DUMMY : S_WDATA;
          end
        end
        S_DUMMY: begin
          if (fall && cnt_q == CNT_DUMMY_END) begin
            state_nxt = S_RDATA;
          end
        end
        default: begin
          state_nxt = state_q;
        end
      endcase
    end
  end

  // Datapath and output decode: counters, address shifting, read nibble selection and write strobe.
  always_comb begin
    cnt_nxt     = cnt_q;
    addr_nxt    = addr_q;
    cmd_hi_nxt  = cmd_hi_q;
    is_read_nxt = is_read_q;
    half_nxt    = half_q;
    hi_nib_nxt  = hi_nib_q;
    sio_nxt     = sio_q;
    oe_nxt      = oe_q;
    mem_we      = 1'b0;
    mem_wdata   = {hi_nib_q, sio_in};

    if (cs_n_high) begin
      cnt_nxt  = CNT_ZERO;
      half_nxt = 1'b0;
      sio_nxt  = 4'h0;
      oe_nxt   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_nxt  = CNT_ZERO;
          half_nxt = 1'b0;
        end
        S_CMD: begin
          if (rise) begin
            cmd_hi_nxt = sio_in;
            if (cnt_q == CNT_ONE) begin
              is_read_nxt = (cmd_byte == CMD_READ);
              cnt_nxt     = CNT_ZERO;
            end else begin
              cnt_nxt = cnt_q + CNT_ONE;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_nxt = (addr_q << 4) | ADDR_W'(sio_in);
            if (cnt_q == CNT_ADDR_LAST) begin
              cnt_nxt = CNT_ZERO;
            end else begin
              cnt_nxt = cnt_q + CNT_ONE;
            end
          end
        end
        S_DUMMY: begin
          if (rise && cnt_q != CNT_DUMMY_END) begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
          if (fall && cnt_q == CNT_DUMMY_END) begin
            sio_nxt  = rd_cur[7:4];
            oe_nxt   = 1'b1;
            half_nxt = 1'b1;
          end
        end
        S_RDATA: begin
          if (fall) begin
            if (half_q) begin
              sio_nxt  = rd_cur[3:0];
              half_nxt = 1'b0;
            end else begin
              addr_nxt = addr_inc;
              sio_nxt  = rd_next[7:4];
              half_nxt = 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            if (!half_q) begin
              hi_nib_nxt = sio_in;
              half_nxt   = 1'b1;
            end else begin
              mem_we   = 1'b1;
              addr_nxt = addr_inc;
              half_nxt = 1'b0;
            end
          end
        end
        default: begin
          cnt_nxt = cnt_q;
        end
      endcase
    end
  end

  // Datapath and output registers; reset matches a deselect.
  always_ff @(posedge i_ram_gck) begin
    if (i_ram_rst) begin
      cnt_q     <= CNT_ZERO;
      addr_q    <= '0;
      cmd_hi_q  <= 4'h0;
      is_read_q <= 1'b0;
      half_q    <= 1'b0;
      hi_nib_q  <= 4'h0;
      sio_q     <= 4'h0;
      oe_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_nxt;
      addr_q    <= addr_nxt;
      cmd_hi_q  <= cmd_hi_nxt;
      is_read_q <= is_read_nxt;
      half_q    <= half_nxt;
      hi_nib_q  <= hi_nib_nxt;
      sio_q     <= sio_nxt;
      oe_q      <= oe_nxt;
    end
  end

  // Byte array write port; contents survive reset but a write never lands during it.
  always_ff @(posedge i_ram_gck) begin
    if (mem_we && !i_ram_rst) begin
      mem[addr_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_idli_sqi_ram_m.sv
// Testbench for idli_sqi_ram_m: acts as the SQI controller, keeps a byte-array
// reference of what memory must hold and compares read-back nibbles and oe.
module tb_idli_sqi_ram_m;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs;
  logic [3:0] sio;
  int         tgt;
  int         ph;
  int         compared;
  int         mismatched;

  logic [3:0] obs_sio;
  logic       obs_oe;

  logic [7:0] model [0:1][0:65535];

  idli_sqi_ram_m_if ifc ();
  idli_sqi_ram_m_if ifc4 ();

  assign ifc.i_ram_sck  = sck;
  assign ifc.i_ram_sio  = sio;
  assign ifc.i_ram_cs   = (tgt == 0) ? cs : 1'b1;
  assign ifc4.i_ram_sck = sck;
  assign ifc4.i_ram_sio = sio;
  assign ifc4.i_ram_cs  = (tgt == 1) ? cs : 1'b1;

  assign obs_sio = (tgt == 0) ? ifc.o_ram_sio : ifc4.o_ram_sio;
  assign obs_oe  = (tgt == 0) ? ifc.o_ram_sio_oe : ifc4.o_ram_sio_oe;

  idli_sqi_ram_m #(.ADDR_W(16), .DUMMY(2)) dut (
    .i_ram_gck (clk),
    .i_ram_rst (rst),
    .bus       (ifc)
  );

  idli_sqi_ram_m #(.ADDR_W(16), .DUMMY(4)) dut4 (
    .i_ram_gck (clk),
    .i_ram_rst (rst),
    .bus       (ifc4)
  );

  // Core clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sck period: sio changes with the low phase, outputs sampled just before the rise.
  task automatic applyStimulus(input logic [3:0] nib, output logic [3:0] rs, output logic ro);
    sio = nib;
    sck = 1'b0;
    repeat (ph) @(negedge clk);
    rs  = obs_sio;
    ro  = obs_oe;
    sck = 1'b1;
    repeat (ph) @(negedge clk);
  endtask

  task automatic sendNib(input logic [3:0] nib, input string tag);
    logic [3:0] rs;
    logic       ro;
    applyStimulus(nib, rs, ro);
    checkOutput({tag, "_oe_low"}, 8'(ro), 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] b, input string tag);
    sendNib(b[7:4], tag);
    sendNib(b[3:0], tag);
  endtask

  task automatic sendAddr(input logic [15:0] a, input string tag);
    sendByte(a[15:8], tag);
    sendByte(a[7:0], tag);
  endtask

  task automatic startTxn();
    cs  = 1'b0;
    sck = 1'b0;
    @(negedge clk);
  endtask

  task automatic endTxn(input string tag);
    sck = 1'b0;
    cs  = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_deselect_oe"}, 8'(obs_oe), 8'h00);
    checkOutput({tag, "_deselect_sio"}, 8'(obs_sio), 8'h00);
    @(negedge clk);
  endtask

  task automatic writeBurst(input logic [15:0] a, input byte_q_t d, input string tag);
    logic [15:0] idx;
    startTxn();
    sendByte(8'h02, {tag, "_cmd"});
    sendAddr(a, {tag, "_addr"});
    foreach (d[i]) begin
      sendByte(d[i], {tag, "_wdata"});
      idx = a + 16'(i);
      model[tgt][idx] = d[i];
    end
    endTxn(tag);
  endtask

  task automatic readBurst(input logic [15:0] a, input int n, input string tag);
    logic [15:0] idx;
    logic [7:0]  exp;
    logic [3:0]  rs;
    logic        ro;
    int          dummies;
    dummies = (tgt == 0) ? 2 : 4;
    startTxn();
    sendByte(8'h03, {tag, "_cmd"});
    sendAddr(a, {tag, "_addr"});
    for (int k = 0; k < dummies; k++) begin
      sendNib(4'($urandom), $sformatf("%s_dummy%0d", tag, k));
    end
    for (int i = 0; i < n; i++) begin
      idx = a + 16'(i);
      exp = model[tgt][idx];
      applyStimulus(4'($urandom), rs, ro);
      checkOutput($sformatf("%s_b%0d_hi", tag, i), 8'(rs), 8'(exp[7:4]));
      checkOutput($sformatf("%s_b%0d_hi_oe", tag, i), 8'(ro), 8'h01);
      applyStimulus(4'($urandom), rs, ro);
      checkOutput($sformatf("%s_b%0d_lo", tag, i), 8'(rs), 8'(exp[3:0]));
      checkOutput($sformatf("%s_b%0d_lo_oe", tag, i), 8'(ro), 8'h01);
    end
    endTxn(tag);
  endtask

  // Deliver a high nibble, then raise sck for the low nibble in the same cycle as deselect.
  task automatic abortWrite(input logic [15:0] a, input string tag);
    startTxn();
    sendByte(8'h02, {tag, "_cmd"});
    sendAddr(a, {tag, "_addr"});
    sendNib(4'hF, {tag, "_hi"});
    sio = 4'h0;
    sck = 1'b0;
    repeat (ph) @(negedge clk);
    cs  = 1'b1;
    sck = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_oe"}, 8'(obs_oe), 8'h00);
    sck = 1'b0;
    @(negedge clk);
  endtask

  task automatic resetWrite(input logic [15:0] a, input string tag);
    startTxn();
    sendByte(8'h02, {tag, "_cmd"});
    sendAddr(a, {tag, "_addr"});
    sendNib(4'hF, {tag, "_hi"});
    sio = 4'h0;
    rst = 1'b1;
    sck = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_oe"}, 8'(obs_oe), 8'h00);
    rst = 1'b0;
    cs  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    byte_q_t     d;
    logic [15:0] ra;
    logic [3:0]  rs;
    logic        ro;
    int          len;

    compared   = 0;
    mismatched = 0;
    tgt = 0;
    ph  = 1;
    rst = 1'b1;
    cs  = 1'b1;
    sck = 1'b0;
    sio = 4'h0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_oe_d2", 8'(ifc.o_ram_sio_oe), 8'h00);
    checkOutput("rst_sio_d2", 8'(ifc.o_ram_sio), 8'h00);
    checkOutput("rst_oe_d4", 8'(ifc4.o_ram_sio_oe), 8'h00);
    checkOutput("rst_sio_d4", 8'(ifc4.o_ram_sio), 8'h00);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] write then read");
    d = '{8'hA5, 8'h3C};
    writeBurst(16'h1234, d, "wr1");
    readBurst(16'h1234, 2, "rd1");

    $display("[TB] address wrap");
    d = '{8'h11, 8'h22};
    writeBurst(16'hFFFF, d, "wrapw");
    readBurst(16'hFFFF, 2, "wrapr");

    $display("[TB] aborted writes");
    d = '{8'h5A};
    writeBurst(16'h0040, d, "abw");
    abortWrite(16'h0040, "abort");
    readBurst(16'h0040, 1, "abort_rd");
    resetWrite(16'h0040, "rstwr");
    readBurst(16'h0040, 1, "rstwr_rd");

    $display("[TB] unknown command");
    startTxn();
    sendByte(8'h9F, "unk_cmd");
    sendNib(4'h1, "unk_n0");
    sendNib(4'h2, "unk_n1");
    sendNib(4'h3, "unk_n2");
    sendNib(4'h4, "unk_n3");
    sendNib(4'hF, "unk_n4");
    sendNib(4'hF, "unk_n5");
    endTxn("unk");
    readBurst(16'h1234, 2, "unk_rd");

    $display("[TB] reset during read data");
    startTxn();
    sendByte(8'h03, "rrd_cmd");
    sendAddr(16'h1234, "rrd_addr");
    sendNib(4'h0, "rrd_d0");
    sendNib(4'h0, "rrd_d1");
    applyStimulus(4'h0, rs, ro);
    checkOutput("rrd_hi", 8'(rs), 8'(model[0][16'h1234][7:4]));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rrd_rst_oe", 8'(obs_oe), 8'h00);
    checkOutput("rrd_rst_sio", 8'(obs_sio), 8'h00);
    rst = 1'b0;
    cs  = 1'b1;
    sck = 1'b0;
    repeat (2) @(negedge clk);
    readBurst(16'h1234, 2, "rrd_after");

    $display("[TB] slow sck");
    ph = 3;
    d = '{8'hA5, 8'h3C};
    writeBurst(16'h2000, d, "sloww");
    readBurst(16'h2000, 2, "slowr");
    ph = 1;

    $display("[TB] four dummy nibbles");
    tgt = 1;
    d = '{8'hA5, 8'h3C};
    writeBurst(16'h1234, d, "d4w");
    readBurst(16'h1234, 2, "d4r");

    $display("[TB] random bursts");
    for (int it = 0; it < 6; it++) begin
      tgt = it % 2;
      ph  = int'($urandom_range(2, 1));
      ra  = 16'($urandom);
      len = int'($urandom_range(4, 1));
      d.delete();
      for (int j = 0; j < len; j++) d.push_back(8'($urandom));
      writeBurst(ra, d, $sformatf("rndw%0d", it));
      readBurst(ra, len, $sformatf("rndr%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
